// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbiter/sequencer between the I/D cache miss handlers and the
// shared multi-cycle main memory. Grants one transaction at a time (D before I),
// issues pipelined block reads, steers returned words into the owning cache,
// and performs single-word write-through stores for the D side.
module mem_arb_ctrl #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic        fill_we,
  output logic        fill_sel,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done,
  output logic        busy
);

  localparam int unsigned DW = $clog2(LATENCY + 1);
  localparam int unsigned IW = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  state_t         state;
  logic           owner;      // 0 = I-cache, 1 = D-cache
  logic [15:0]    base;
  logic [IW-1:0]  issue_cnt;
  logic [2:0]     rcv_cnt;
  logic [DW-1:0]  drain_cnt;

  logic           issuing;
  logic           last_word;

  assign issuing   = (state == FILL) && (issue_cnt < IW'(WORDS));
  assign last_word = (state == FILL) && mem_valid && (rcv_cnt == 3'(WORDS - 1));

  // Sequencer: grant, issue/receive counting, and post-reset drain of stale responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      base      <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      drain_cnt <= DW'(LATENCY);
    end else begin
      case (state)
        IDLE: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
          end else if (d_req && d_wr) begin
            state <= WRITE;
          end else if (d_req) begin
            state <= FILL;
            owner <= 1'b1;
            base  <= d_addr & 16'hFFF0;
          end else if (i_req) begin
            state <= FILL;
            owner <= 1'b0;
            base  <= i_addr & 16'hFFF0;
          end
        end
        FILL: begin
          if (issuing)   issue_cnt <= issue_cnt + 1'b1;
          if (mem_valid) rcv_cnt   <= rcv_cnt + 1'b1;
          if (last_word) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from registered state; fill/done depend on mem_valid because
  // the returned word and its completion pulse share the response cycle.
  always_comb begin
    mem_en    = issuing || (state == WRITE);
    mem_wr    = (state == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WRITE) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (issuing) begin
      mem_addr = base + (16'(issue_cnt) << 1);
    end
    fill_we   = (state == FILL) && mem_valid;
    fill_sel  = fill_we && owner;
    fill_word = fill_we ? rcv_cnt : '0;
    fill_data = fill_we ? mem_rdata : '0;
    i_done    = last_word && !owner;
    d_done    = (last_word && owner) || (state == WRITE);
    busy      = (state != IDLE);
  end

endmodule
